hash_finalize: RTL and testbench
================================

HASH_FINALIZE -- requirements
Module: hash_finalize

Interface
REQ-001 SHALL have parameter HASH_LENGTH, default 8, number of 32-bit hash words.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable  input  1  stage enable; low forces idle.
REQ-005 SHALL have port rounds_done  input  1  single-cycle pulse: compression rounds complete.
REQ-006 SHALL have port new_message  input  1  start of a new message (chain restart).
REQ-007 SHALL have port working_vector  input  256  working variables a..h; word i at bits [32i+31:32i], a = word 0.
REQ-008 SHALL have port hash_vector  output  256  final digest words H0..H7, same word packing.
REQ-009 SHALL have port hash_valid  output  1  hash_vector stable and valid.
REQ-010 SHALL have port h_address  output  $clog2(HASH_LENGTH)  word index presented to the store stage.
REQ-011 SHALL have port address_read_complete  output  1  all words presented.
REQ-012 SHALL have port busy  output  1  state not IDLE.

Function
REQ-013 SHALL implement states IDLE, ADD, EMIT, DONE.
REQ-014 IDLE -> ADD on the first cycle with enable=1 and rounds_done=1; the word counter clears to 0.
REQ-015 In ADD: one word per cycle; hash_vector word k <= H_base[k] + working_vector word k, modulo 2^32, carry discarded; k increments 0..HASH_LENGTH-1.
REQ-016 ADD -> EMIT after word HASH_LENGTH-1 is written; hash_valid asserts on entry to EMIT and holds through DONE.
REQ-017 In EMIT: h_address steps 0,1,...,HASH_LENGTH-1, one value per cycle.
REQ-018 EMIT -> DONE after h_address = HASH_LENGTH-1; address_read_complete = 1 in DONE.
REQ-019 DONE -> IDLE when enable=0.
REQ-020 Latency: rounds_done at cycle T gives hash_valid at T+9, h_address=0 at T+9, h_address=7 at T+16, address_read_complete at T+17 (HASH_LENGTH=8).
REQ-021 rounds_done outside IDLE SHALL be ignored, with no restart and no queuing.
REQ-022 enable=0 in any state SHALL return to IDLE next cycle, clearing hash_valid, address_read_complete, h_address; hash_vector retained.
REQ-023 H_base SHALL be the SHA-256 IV, unless overridden per REQ-028.
REQ-024 working_vector SHALL be sampled each ADD cycle; upstream holds it stable from rounds_done until EMIT.

Reset
REQ-025 Reset SHALL force IDLE, word counter 0, h_address 0, hash_valid 0, address_read_complete 0, busy 0, and hash_vector to the SHA-256 IV.
REQ-026 Reset SHALL take priority over enable, rounds_done and new_message, including mid-ADD or mid-EMIT.

Configuration
REQ-027 Macro HASH_CHAIN_EN SHALL select multi-block chaining.
REQ-028 With HASH_CHAIN_EN defined: H_base = current hash_vector (previous block digest); new_message=1 in IDLE reloads hash_vector with the IV; new_message coincident with rounds_done reloads first, then ADD uses the IV.
REQ-029 Without HASH_CHAIN_EN: H_base is always the IV; new_message is ignored.

Structure
REQ-030 Shared package sha256_pkg SHALL hold the eight IV constants, the state enum and the WORD_W=32 constant.
REQ-031 A sub-module add32 (32-bit modular adder, purely combinational) SHALL be instantiated once and time-shared across words.

Verification
REQ-032 working_vector=0, rounds_done pulse -> hash_vector word0=6a09e667, word7=5be0cd19, hash_valid at T+9.
REQ-033 All working words=FFFFFFFF -> word0=6a09e666, word7=5be0cd18 (wrap, carry dropped).
REQ-034 enable dropped at T+12 (mid-EMIT) -> IDLE at T+13, h_address=0, address_read_complete=0; a re-issued rounds_done then completes normally.
REQ-035 Second rounds_done during ADD -> ignored; exactly 8 EMIT addresses, single completion.
REQ-036 HASH_CHAIN_EN, two blocks with working words all 1, no new_message -> word0 = 6a09e669; with new_message before block 2 -> 6a09e668.
REQ-037 Reset asserted mid-ADD -> next cycle all outputs at reset values, hash_vector=IV.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 finalize constants, IV and state encoding
package sha256_pkg;

  localparam int WORD_W   = 32;
  localparam int IV_WORDS = 8;

  // Word i sits at bits [32i+31:32i]; H0 is the least significant word.
  localparam logic [IV_WORDS*WORD_W-1:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/hash_finalize_if.sv
// rtl/hash_finalize_if.sv - control/data bundle between compression rounds and the finalize stage
interface hash_finalize_if
  import sha256_pkg::*;
#(
  parameter int HASH_LENGTH = 8
);
  localparam int VEC_W  = HASH_LENGTH * WORD_W;
  localparam int ADDR_W = $clog2(HASH_LENGTH);

  logic              enable;
  logic              rounds_done;
  logic              new_message;
  logic [VEC_W-1:0]  working_vector;
  logic [VEC_W-1:0]  hash_vector;
  logic              hash_valid;
  logic [ADDR_W-1:0] h_address;
  logic              address_read_complete;
  logic              busy;

  modport master (
    output enable, rounds_done, new_message, working_vector,
    input  hash_vector, hash_valid, h_address, address_read_complete, busy
  );

  modport slave (
    input  enable, rounds_done, new_message, working_vector,
    output hash_vector, hash_valid, h_address, address_read_complete, busy
  );

endinterface

// File: rtl/hash_finalize_add32.sv
// rtl/hash_finalize_add32.sv - combinational modulo-2^32 adder shared across digest words
module add32
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/hash_finalize.sv
// rtl/hash_finalize.sv - adds working variables onto the base hash one word per cycle, then walks word addresses; HASH_CHAIN_EN enables multi-block chaining
module hash_finalize
  import sha256_pkg::*;
#(
  parameter int HASH_LENGTH = 8
)(
  input  logic           clock,
  input  logic           reset,
  hash_finalize_if.slave bus
);

  localparam int VEC_W  = HASH_LENGTH * WORD_W;
  localparam int ADDR_W = $clog2(HASH_LENGTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(HASH_LENGTH - 1);
  localparam logic [VEC_W-1:0]  IV_VEC = VEC_W'(SHA256_IV);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] h_address_q;
  logic [VEC_W-1:0]  hash_q;
  logic [WORD_W-1:0] base_word;
  logic [WORD_W-1:0] work_word;
  logic [WORD_W-1:0] sum_word;

  assign work_word = bus.working_vector[int'(word_count)*WORD_W +: WORD_W];

`ifdef HASH_CHAIN_EN
  // Chained blocks add onto the previous digest held in hash_q.
  assign base_word = hash_q[int'(word_count)*WORD_W +: WORD_W];
`else
  logic unused_new_message;
  assign unused_new_message = bus.new_message;
  assign base_word = IV_VEC[int'(word_count)*WORD_W +: WORD_W];
`endif

  add32 u_add32 (
    .a   (base_word),
    .b   (work_word),
    .sum (sum_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.rounds_done) state_d = ADD;
        ADD:  if (word_count == LAST) state_d = EMIT;
        EMIT: if (h_address_q == LAST) state_d = DONE;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hash_q      <= IV_VEC;
      word_count  <= '0;
      h_address_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          word_count  <= '0;
          h_address_q <= '0;
`ifdef HASH_CHAIN_EN
          // Reloading here means a coincident rounds_done starts ADD from the IV.
          if (bus.new_message) hash_q <= IV_VEC;
`endif
        end
        ADD: begin
          if (bus.enable) begin
            hash_q[int'(word_count)*WORD_W +: WORD_W] <= sum_word;
            word_count <= (word_count == LAST) ? '0 : word_count + 1'b1;
          end
        end
        EMIT: begin
          if (bus.enable && h_address_q != LAST) h_address_q <= h_address_q + 1'b1;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
      if (!bus.enable) begin
        h_address_q <= '0;
        word_count  <= '0;
      end
    end
  end

  assign bus.hash_vector           = hash_q;
  assign bus.hash_valid            = (state_q == EMIT) || (state_q == DONE);
  assign bus.h_address             = h_address_q;
  assign bus.address_read_complete = (state_q == DONE);
  assign bus.busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_hash_finalize.sv
// tb/tb_hash_finalize.sv - randomized self-checking bench for hash_finalize against a word-array digest model
module tb_hash_finalize;

  logic clock = 1'b0;
  logic reset;

  hash_finalize_if #(.HASH_LENGTH(8)) bus ();

  hash_finalize #(.HASH_LENGTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [31:0] iv_w [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] model_h [8];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = model_h[k];
    return v;
  endfunction

  function automatic logic [255:0] iv_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = iv_w[k];
    return v;
  endfunction

  task automatic model_apply(input logic [255:0] w, input bit nm);
`ifdef HASH_CHAIN_EN
    if (nm) model_h = iv_w;
    for (int k = 0; k < 8; k++) model_h[k] = model_h[k] + w[32*k +: 32];
`else
    for (int k = 0; k < 8; k++) model_h[k] = iv_w[k] + w[32*k +: 32];
`endif
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // Drives rounds_done in cycle T; returns in cycle T+1.
  task automatic start_block(input logic [255:0] w, input bit nm);
    bus.working_vector = w;
    bus.new_message    = nm;
    bus.rounds_done    = 1'b1;
    tick();
    bus.rounds_done = 1'b0;
    bus.new_message = 1'b0;
  endtask

  task automatic drop_enable();
    bus.enable = 1'b0;
    tick();
    check("idle_busy", 256'(bus.busy), 256'd0);
    bus.enable = 1'b1;
  endtask

  task automatic run_block(input string tag, input logic [255:0] w, input bit nm);
    start_block(w, nm);
    model_apply(w, nm);
    repeat (7) tick();
    check({tag, "_valid_t8"}, 256'(bus.hash_valid), 256'd0);
    tick();
    check({tag, "_valid_t9"}, 256'(bus.hash_valid), 256'd1);
    check({tag, "_digest"}, bus.hash_vector, model_vec());
    for (int a = 0; a < 8; a++) begin
      check({tag, "_addr"}, 256'(bus.h_address), 256'(a));
      check({tag, "_arc_emit"}, 256'(bus.address_read_complete), 256'd0);
      tick();
    end
    check({tag, "_arc_t17"}, 256'(bus.address_read_complete), 256'd1);
    check({tag, "_valid_done"}, 256'(bus.hash_valid), 256'd1);
    drop_enable();
  endtask

  initial begin
    logic [255:0] w;
    int n;

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.rounds_done = 1'b0;
    bus.new_message = 1'b0;
    bus.working_vector = '0;
    model_h = iv_w;
    tick();
    tick();
    check("rst_hash", bus.hash_vector, iv_vec());
    check("rst_valid", 256'(bus.hash_valid), 256'd0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_addr", 256'(bus.h_address), 256'd0);
    check("rst_arc", 256'(bus.address_read_complete), 256'd0);
    reset = 1'b0;
    bus.enable = 1'b1;
    tick();

    run_block("zero", '0, 1'b1);
    check("zero_w0", 256'(bus.hash_vector[31:0]), 256'(32'h6a09e667));
    check("zero_w7", 256'(bus.hash_vector[255:224]), 256'(32'h5be0cd19));

    run_block("ones", {256{1'b1}}, 1'b1);
    check("wrap_w0", 256'(bus.hash_vector[31:0]), 256'(32'h6a09e666));
    check("wrap_w7", 256'(bus.hash_vector[255:224]), 256'(32'h5be0cd18));

    for (int i = 0; i < 4; i++) run_block("rand", rand_vec(), 1'($urandom_range(0, 1)));

    // enable drop mid-EMIT
    w = rand_vec();
    start_block(w, 1'b0);
    model_apply(w, 1'b0);
    repeat (11) tick();
    bus.enable = 1'b0;
    tick();
    check("abort_busy", 256'(bus.busy), 256'd0);
    check("abort_addr", 256'(bus.h_address), 256'd0);
    check("abort_arc", 256'(bus.address_read_complete), 256'd0);
    check("abort_valid", 256'(bus.hash_valid), 256'd0);
    check("abort_hash", bus.hash_vector, model_vec());
    bus.enable = 1'b1;
    run_block("reissue", rand_vec(), 1'b0);

    // second rounds_done during ADD
    w = rand_vec();
    start_block(w, 1'b0);
    model_apply(w, 1'b0);
    tick();
    tick();
    bus.rounds_done = 1'b1;
    tick();
    bus.rounds_done = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.address_read_complete) break;
      if (bus.hash_valid) n++;
      tick();
    end
    check("dup_emit_count", 256'(n), 256'd8);
    check("dup_arc", 256'(bus.address_read_complete), 256'd1);
    check("dup_digest", bus.hash_vector, model_vec());
    tick();
    tick();
    check("dup_no_restart", 256'(bus.address_read_complete), 256'd1);
    drop_enable();

    // reset mid-ADD
    start_block(rand_vec(), 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_hash", bus.hash_vector, iv_vec());
    check("mid_rst_busy", 256'(bus.busy), 256'd0);
    check("mid_rst_valid", 256'(bus.hash_valid), 256'd0);
    check("mid_rst_addr", 256'(bus.h_address), 256'd0);
    check("mid_rst_arc", 256'(bus.address_read_complete), 256'd0);
    reset = 1'b0;
    model_h = iv_w;
    tick();

    // chaining: two all-one blocks, then a new message
    w = '0;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'd1;
    run_block("chain1", w, 1'b0);
    check("chain1_w0", 256'(bus.hash_vector[31:0]), 256'(32'h6a09e668));
    run_block("chain2", w, 1'b0);
`ifdef HASH_CHAIN_EN
    check("chain2_w0", 256'(bus.hash_vector[31:0]), 256'(32'h6a09e669));
`else
    check("chain2_w0", 256'(bus.hash_vector[31:0]), 256'(32'h6a09e668));
`endif
    bus.new_message = 1'b1;
    tick();
    bus.new_message = 1'b0;
    model_h = iv_w;
    run_block("chain_new", w, 1'b0);
    check("chain_new_w0", 256'(bus.hash_vector[31:0]), 256'(32'h6a09e668));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
